wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage RISC-V core. It accepts one instruction per cycle from the MEM stage, waits for data-memory responses on loads, and aligns and sign- or zero-extends the load data. It drives the register file write port (`write_regf_en`, `addr_rd`, `rd_value`) from registered outputs. It also stalls upstream while a load response is outstanding and counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `CNT_W`, 64, width of the retired-instruction counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_valid` in 1: MEM stage presents an instruction.
- `mem_reg_write` in 1: instruction writes rd.
- `mem_rd` in 5: destination register.
- `mem_alu_result` in 32: ALU result; for loads, the effective address.
- `mem_is_load` in 1: instruction is a load.
- `mem_funct3` in 3: load size/sign code.
- `dmem_rdata` in 32: data-memory read word, word-aligned.
- `dmem_rvalid` in 1: `dmem_rdata` is valid this cycle.
- `wb_stall` out 1: upstream must hold all `mem_*` stable.
- `write_regf_en` out 1: register-file write strobe.
- `addr_rd` out 5: register-file write address.
- `rd_value` out 32: register-file write data.
- `instret` out `CNT_W`: retired-instruction count.

## Operation
- FSM has two states: RUN and WAIT_LOAD.
- `wb_stall` = (state == WAIT_LOAD), combinational from state only.
- Acceptance happens on an edge where `mem_valid && !wb_stall`.
- **RUN, accepted non-load:**
  - `write_regf_en` <= `mem_reg_write && (mem_rd != 0)`.
  - `addr_rd` <= `mem_rd`; `rd_value` <= `mem_alu_result`.
  - Counts as retired.
- **RUN, accepted load with `dmem_rvalid`=1:** same as the non-load case, except `rd_value` <= align(`dmem_rdata`). Counts as retired.
- **RUN, accepted load with `dmem_rvalid`=0:**
  - Latch rd, reg_write, funct3 and offset = `mem_alu_result[1:0]`.
  - `write_regf_en` <= 0; go to WAIT_LOAD.
- **WAIT_LOAD:**
  - `write_regf_en` <= 0 each cycle until `dmem_rvalid`.
  - On `dmem_rvalid`: outputs take the latched rd/reg_write and the aligned data; count as retired; go to RUN.
- **No acceptance in RUN:** `write_regf_en` <= 0; `addr_rd` and `rd_value` hold.
- `dmem_rvalid` is ignored in RUN unless a load is accepted the same cycle.
- **align():**
  - funct3 000 (LB): byte at offset, sign-extended.
  - 100 (LBU): byte at offset, zero-extended.
  - 001 (LH): halfword at `offset[1]`, sign-extended.
  - 101 (LHU): halfword at `offset[1]`, zero-extended.
  - 010 (LW): full word.
  - 011/110/111: treated as LW.
  - `offset[0]` is ignored for halfwords; offset is ignored for words. No misalignment trap.
- `instret` increments by 1 per retired instruction, including rd=0 and non-writing instructions. It wraps modulo 2^`CNT_W`.

## Timing
- Reset values: state RUN, `wb_stall` 0, `write_regf_en` 0, `addr_rd` 0, `rd_value` 0, `instret` 0.
- Non-load, or load with same-cycle rvalid: accepted at edge N; `write_regf_en` high during cycle N..N+1; the register file updates at edge N+1.
- Load with rvalid k cycles after acceptance (k≥1): `wb_stall` is high for k cycles, including the rvalid cycle. Write strobe follows the rvalid edge; the next instruction is accepted the cycle after.
- `write_regf_en` is a one-cycle pulse per writing instruction. Back-to-back non-loads produce consecutive pulses.
- Reset during WAIT_LOAD: the pending load is discarded, with no write and no `instret` increment.
- A `dmem_rvalid` arriving in the reset cycle is ignored.

## Test plan
- **Reset:** assert `rst` 2 cycles with random inputs -> all outputs 0, `wb_stall` 0.
- **Back-to-back ALU:** x5=0x11, x6=0x22, x0=0x33, with `mem_reg_write`=1 -> strobes for x5 and x6 in consecutive cycles; no strobe for x0; `instret`=3.
- **Same-cycle loads:** `dmem_rdata`=0x8070F0A5.
  - LB offset 0 -> 0xFFFFFFA5.
  - LBU offset 1 -> 0x000000F0.
  - LH offset 2 -> 0xFFFF8070.
  - LHU offset 3 -> 0x00008070.
  - LW -> 0x8070F0A5.
- **Delayed load:** LW to x7, rvalid 3 cycles later with 0xDEADBEEF.
  - `wb_stall` high for exactly 3 cycles.
  - The following ALU instruction (x8=0x5) is held, then written one cycle after x7.
- **Reset mid-wait:** LW pending 2 cycles, then `rst` -> no write, `instret` 0, state RUN.
- **Counter wrap:** with `CNT_W`=4, retire 17 instructions -> `instret`=1.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, waits on outstanding load
// responses, aligns/extends load data and drives the register-file write port.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic             mem_is_load,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             wb_stall,
  output logic             write_regf_en,
  output logic [4:0]       addr_rd,
  output logic [XLEN-1:0]  rd_value,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {
    RUN,
    WAIT_LOAD
  } state_t;

  state_t          state, state_next;
  logic [4:0]      lat_rd, lat_rd_next;
  logic            lat_reg_write, lat_reg_write_next;
  logic [2:0]      lat_funct3, lat_funct3_next;
  logic [1:0]      lat_offset, lat_offset_next;
  logic            wen_next;
  logic [4:0]      rd_next;
  logic [XLEN-1:0] value_next;
  logic            retire;

  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] word,
                                            input logic [2:0]      funct3,
                                            input logic [1:0]      offset);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = word[8*offset +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  align = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  align = {24'h0, byte_sel};
      3'b001:  align = {{16{half_sel[15]}}, half_sel};
      3'b101:  align = {16'h0, half_sel};
      default: align = word;
    endcase
  endfunction

  assign wb_stall = (state == WAIT_LOAD);

  always_comb begin
    state_next         = state;
    lat_rd_next        = lat_rd;
    lat_reg_write_next = lat_reg_write;
    lat_funct3_next    = lat_funct3;
    lat_offset_next    = lat_offset;
    wen_next           = 1'b0;
    rd_next            = addr_rd;
    value_next         = rd_value;
    retire             = 1'b0;
    case (state)
      RUN: begin
        if (mem_valid) begin
          if (mem_is_load && !dmem_rvalid) begin
            lat_rd_next        = mem_rd;
            lat_reg_write_next = mem_reg_write;
            lat_funct3_next    = mem_funct3;
            lat_offset_next    = mem_alu_result[1:0];
            state_next         = WAIT_LOAD;
          end else begin
            wen_next   = mem_reg_write && (mem_rd != 5'd0);
            rd_next    = mem_rd;
            value_next = mem_is_load ? align(dmem_rdata, mem_funct3, mem_alu_result[1:0])
                                     : mem_alu_result;
            retire     = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          wen_next   = lat_reg_write && (lat_rd != 5'd0);
          rd_next    = lat_rd;
          value_next = align(dmem_rdata, lat_funct3, lat_offset);
          retire     = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Reset wins over a pending load: nothing written, nothing counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      lat_rd        <= 5'd0;
      lat_reg_write <= 1'b0;
      lat_funct3    <= 3'd0;
      lat_offset    <= 2'd0;
      write_regf_en <= 1'b0;
      addr_rd       <= 5'd0;
      rd_value      <= '0;
      instret       <= '0;
    end else begin
      state         <= state_next;
      lat_rd        <= lat_rd_next;
      lat_reg_write <= lat_reg_write_next;
      lat_funct3    <= lat_funct3_next;
      lat_offset    <= lat_offset_next;
      write_regf_en <= wen_next;
      addr_rd       <= rd_next;
      rd_value      <= value_next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; a second instance with a 4-bit
// counter shares the stimulus to exercise instret wrap-around.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_reg_write, mem_is_load, dmem_rvalid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, dmem_rdata;
  logic [2:0]  mem_funct3;
  logic        wb_stall, write_regf_en;
  logic [4:0]  addr_rd;
  logic [31:0] rd_value;
  logic [63:0] instret;
  logic        wb_stall4, write_regf_en4;
  logic [4:0]  addr_rd4;
  logic [31:0] rd_value4;
  logic [3:0]  instret4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .wb_stall(wb_stall), .write_regf_en(write_regf_en), .addr_rd(addr_rd),
    .rd_value(rd_value), .instret(instret)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_is_load(mem_is_load),
    .mem_funct3(mem_funct3), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .wb_stall(wb_stall4), .write_regf_en(write_regf_en4), .addr_rd(addr_rd4),
    .rd_value(rd_value4), .instret(instret4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_alu_result = 32'h0;
    mem_is_load = 1'b0; mem_funct3 = 3'd0; dmem_rdata = 32'h0; dmem_rvalid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = rd; mem_alu_result = val;
    mem_is_load = 1'b0; mem_funct3 = 3'd0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_valid = $urandom_range(0, 1); mem_reg_write = $urandom_range(0, 1);
    mem_rd = 5'($urandom); mem_alu_result = $urandom; mem_is_load = $urandom_range(0, 1);
    mem_funct3 = 3'($urandom); dmem_rdata = $urandom; dmem_rvalid = $urandom_range(0, 1);
    step();
    step();
    tests++;
    if ({wb_stall, write_regf_en, addr_rd, rd_value} !== 39'h0 || instret !== 64'h0) begin
      fails++;
      $display("FAIL reset: stall=%0b wen=%0b rd=%0d val=%h instret=%0d, expected all 0",
               wb_stall, write_regf_en, addr_rd, rd_value, instret);
    end
    idle();
    rst = 1'b0;
    step();
    tests++;
    if (write_regf_en !== 1'b0 || wb_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: wen=%0b stall=%0b, expected 0 0", write_regf_en, wb_stall);
    end
  endtask

  task automatic test_back_to_back();
    int strobes = 0;
    alu(5'd5, 32'h11);
    step();
    strobes += int'(write_regf_en);
    tests++;
    if (write_regf_en !== 1'b1 || addr_rd !== 5'd5 || rd_value !== 32'h11) begin
      fails++;
      $display("FAIL b2b_x5: wen=%0b rd=%0d val=%h, expected 1 5 00000011",
               write_regf_en, addr_rd, rd_value);
    end
    alu(5'd6, 32'h22);
    step();
    strobes += int'(write_regf_en);
    tests++;
    if (write_regf_en !== 1'b1 || addr_rd !== 5'd6 || rd_value !== 32'h22) begin
      fails++;
      $display("FAIL b2b_x6: wen=%0b rd=%0d val=%h, expected 1 6 00000022",
               write_regf_en, addr_rd, rd_value);
    end
    alu(5'd0, 32'h33);
    step();
    strobes += int'(write_regf_en);
    tests++;
    if (write_regf_en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_x0: wen=%0b, expected 0", write_regf_en);
    end
    idle();
    dmem_rvalid = 1'b1;
    step();
    strobes += int'(write_regf_en);
    tests++;
    if (write_regf_en !== 1'b0 || addr_rd !== 5'd0 || rd_value !== 32'h33) begin
      fails++;
      $display("FAIL b2b_idle: wen=%0b rd=%0d val=%h, expected 0 0 00000033",
               write_regf_en, addr_rd, rd_value);
    end
    dmem_rvalid = 1'b0;
    tests++;
    if (strobes != 2 || instret !== 64'd3) begin
      fails++;
      $display("FAIL b2b_count: strobes=%0d instret=%0d, expected 2 3", strobes, instret);
    end
  endtask

  task automatic test_same_cycle_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  off [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] exp [5] = '{32'hFFFFFFA5, 32'h000000F0, 32'hFFFF8070, 32'h00008070, 32'h8070F0A5};
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd10 + 5'(i);
      mem_alu_result = {30'h100, off[i]}; mem_is_load = 1'b1; mem_funct3 = f3[i];
      dmem_rdata = 32'h8070F0A5; dmem_rvalid = 1'b1;
      step();
      tests++;
      if (write_regf_en !== 1'b1 || addr_rd !== 5'd10 + 5'(i) || rd_value !== exp[i] ||
          wb_stall !== 1'b0) begin
        fails++;
        $display("FAIL load_%0d: wen=%0b rd=%0d val=%h stall=%0b, expected 1 %0d %h 0",
                 i, write_regf_en, addr_rd, rd_value, wb_stall, 10 + i, exp[i]);
      end
    end
    idle();
    step();
    tests++;
    if (instret !== 64'd8) begin
      fails++;
      $display("FAIL load_count: instret=%0d, expected 8", instret);
    end
  endtask

  task automatic test_delayed_load();
    int stall_cycles = 0;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7; mem_alu_result = 32'h200;
    mem_is_load = 1'b1; mem_funct3 = 3'b010; dmem_rvalid = 1'b0;
    step();
    alu(5'd8, 32'h5);
    for (int c = 0; c < 3; c++) begin
      stall_cycles += int'(wb_stall);
      tests++;
      if (write_regf_en !== 1'b0) begin
        fails++;
        $display("FAIL dload_wait_%0d: wen=%0b, expected 0", c, write_regf_en);
      end
      if (c == 2) begin
        dmem_rdata = 32'hDEADBEEF; dmem_rvalid = 1'b1;
      end
      step();
    end
    stall_cycles += int'(wb_stall);
    tests++;
    if (write_regf_en !== 1'b1 || addr_rd !== 5'd7 || rd_value !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL dload_x7: wen=%0b rd=%0d val=%h, expected 1 7 deadbeef",
               write_regf_en, addr_rd, rd_value);
    end
    dmem_rvalid = 1'b0;
    step();
    tests++;
    if (write_regf_en !== 1'b1 || addr_rd !== 5'd8 || rd_value !== 32'h5) begin
      fails++;
      $display("FAIL dload_x8: wen=%0b rd=%0d val=%h, expected 1 8 00000005",
               write_regf_en, addr_rd, rd_value);
    end
    idle();
    step();
    tests++;
    if (stall_cycles != 3 || instret !== 64'd10) begin
      fails++;
      $display("FAIL dload_stall: stall_cycles=%0d instret=%0d, expected 3 10",
               stall_cycles, instret);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd9; mem_alu_result = 32'h300;
    mem_is_load = 1'b1; mem_funct3 = 3'b010; dmem_rvalid = 1'b0;
    step();
    idle();
    step();
    tests++;
    if (wb_stall !== 1'b1) begin
      fails++;
      $display("FAIL rmw_pending: stall=%0b, expected 1", wb_stall);
    end
    rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    step();
    rst = 1'b0; dmem_rvalid = 1'b0;
    step();
    tests++;
    if (write_regf_en !== 1'b0 || wb_stall !== 1'b0 || instret !== 64'd0 ||
        addr_rd !== 5'd0) begin
      fails++;
      $display("FAIL rmw_discard: wen=%0b stall=%0b instret=%0d rd=%0d, expected 0 0 0 0",
               write_regf_en, wb_stall, instret, addr_rd);
    end
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 17; i++) begin
      alu(5'd1, 32'(i));
      step();
    end
    idle();
    step();
    tests++;
    if (instret4 !== 4'd1 || instret !== 64'd17) begin
      fails++;
      $display("FAIL wrap: instret4=%0d instret=%0d, expected 1 17", instret4, instret);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_same_cycle_loads();
    test_delayed_load();
    test_reset_mid_wait();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
